// File: rtl/rx_frame_controller.sv
// rx_frame_controller: captures one rx frame from the deserialiser into a local
// byte buffer, checks CRC_A over it, reports status with a one-cycle frame_done,
// then drains the buffered bytes to the protocol layer over valid/ready.
//
// state  | meaning
// IDLE   | waiting for in_soc; status of the last frame is held
// RX     | capturing bytes and running CRC_A
// RX_ERR | rx error or illegal partial byte seen; data ignored until in_eoc
// CHECK  | one cycle: register crc_ok and raise frame_done
// DRAIN  | presenting buffered bytes to the consumer
module rx_frame_controller #(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_soc,
  input  logic             in_eoc,
  input  logic             in_error,
  input  logic             in_data_valid,
  input  logic [7:0]       in_data,
  input  logic [2:0]       in_data_bits,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic [2:0]       last_bits,
  output logic             crc_ok,
  output logic             error_seen,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, RX, RX_ERR, CHECK, DRAIN} state_t;

  state_t           state, state_nx;
  logic [7:0]       mem [MAX_BYTES];
  logic [LEN_W-1:0] wr_ptr, rd_ptr;
  logic [15:0]      crc;
  logic             start, store, discard, flag_err, xfer, full;

  // CRC_A, reflected poly 0x8408, one byte LSb first, unrolled over 8 bit steps
  function automatic logic [15:0] crc_a_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign full      = (wr_ptr == LEN_W'(MAX_BYTES));
  assign frame_len = wr_ptr;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && ((rd_ptr + LEN_W'(1)) == wr_ptr);
  assign out_data  = (state == DRAIN) ? mem[rd_ptr[AW-1:0]] : 8'h00;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and datapath strobes; in_soc always wins and restarts capture
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    store    = 1'b0;
    discard  = 1'b0;
    flag_err = 1'b0;
    xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (in_soc) begin
          start    = 1'b1;
          state_nx = RX;
        end
      end
      RX: begin
        if (in_soc) begin
          start    = 1'b1;
          state_nx = RX;
        end else if (in_error) begin
          flag_err = 1'b1;
          state_nx = in_eoc ? CHECK : RX_ERR;
        end else begin
          if (in_data_valid) begin
            if ((in_data_bits != 3'd0) && !in_eoc) begin
              flag_err = 1'b1;
              state_nx = RX_ERR;
            end else if (full) begin
              discard = 1'b1;
            end else begin
              store = 1'b1;
            end
          end
          if (in_eoc) state_nx = CHECK;
        end
      end
      RX_ERR: begin
        if (in_soc) begin
          start    = 1'b1;
          state_nx = RX;
        end else if (in_eoc) begin
          state_nx = CHECK;
        end
      end
      CHECK: begin
        state_nx = (wr_ptr != '0) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (in_soc) begin
          start    = 1'b1;
          state_nx = RX;
        end else if (out_ready) begin
          xfer = 1'b1;
          if (out_last) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // frame status, pointers and running CRC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_bits  <= 3'd0;
      crc        <= 16'h6363;
      error_seen <= 1'b0;
      overflow   <= 1'b0;
      crc_ok     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == CHECK);
      if (start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        last_bits  <= 3'd0;
        crc        <= 16'h6363;
        error_seen <= 1'b0;
        overflow   <= 1'b0;
        crc_ok     <= 1'b0;
      end else begin
        if (store) begin
          wr_ptr    <= wr_ptr + LEN_W'(1);
          last_bits <= in_data_bits;
          // a partial last byte is buffered but never enters the CRC
          if (in_data_bits == 3'd0) crc <= crc_a_byte(crc, in_data);
        end
        if (discard)  overflow   <= 1'b1;
        if (flag_err) error_seen <= 1'b1;
        if (state == CHECK)
          crc_ok <= (crc == 16'h0000) && (wr_ptr >= LEN_W'(3)) && (last_bits == 3'd0)
                    && !error_seen && !overflow;
        if (xfer) rd_ptr <= rd_ptr + LEN_W'(1);
      end
    end
  end

  // byte buffer; no reset needed because reads are gated by DRAIN
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: frame-level reference model feeds a scoreboard
// of expected status and drained bytes; a monitor pops and compares.
module tb_rx_frame_controller;

  localparam int MAX = 16;
  localparam int LW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_soc = 1'b0, in_eoc = 1'b0, in_error = 1'b0, in_data_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic [2:0]    in_data_bits = 3'd0;
  logic          frame_done, crc_ok, error_seen, overflow, out_valid, out_last, busy;
  logic [LW-1:0] frame_len;
  logic [2:0]    last_bits;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;

  rx_frame_controller #(.MAX_BYTES(MAX)) dut (
    .clk(clk), .rst(rst), .in_soc(in_soc), .in_eoc(in_eoc), .in_error(in_error),
    .in_data_valid(in_data_valid), .in_data(in_data), .in_data_bits(in_data_bits),
    .frame_done(frame_done), .frame_len(frame_len), .last_bits(last_bits),
    .crc_ok(crc_ok), .error_seen(error_seen), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int len; int lb; int ok; int err; int ovf; int cyc; } status_t;
  typedef struct { logic [7:0] d; logic l; } byte_t;
  status_t sq[$];
  byte_t   bq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    logic fb;
    c = c_in;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ d[k];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  // consumer readiness: 0 random, 1 held low, 2 held high
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // monitor: status on frame_done, bytes on each handshake, hold while stalled
  initial begin
    status_t s;
    byte_t   b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done) begin
          if (sq.size() == 0) fail_now("frame_done_unexpected");
          else begin
            s = sq.pop_front();
            chk("fd_latency", cyc, s.cyc + 2);
            chk("frame_len", int'(frame_len), s.len);
            chk("last_bits", int'(last_bits), s.lb);
            chk("crc_ok", int'(crc_ok), s.ok);
            chk("error_seen", int'(error_seen), s.err);
            chk("overflow", int'(overflow), s.ovf);
          end
        end
        if (out_valid) begin
          if (bq.size() == 0) fail_now("out_valid_unexpected");
          else if (out_ready) begin
            b = bq.pop_front();
            chk("out_data", int'(out_data), int'(b.d));
            chk("out_last", int'(out_last), int'(b.l));
          end else begin
            chk("hold_data", int'(out_data), int'(bq[0].d));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic soc, input logic eoc, input logic err, input logic dv,
                       input logic [7:0] d, input logic [2:0] bits);
    @(posedge clk);
    #1;
    in_soc = soc; in_eoc = eoc; in_error = err; in_data_valid = dv;
    in_data = d; in_data_bits = bits;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_frame_len"}, int'(frame_len), 0);
    chk({tag, "_last_bits"}, int'(last_bits), 0);
    chk({tag, "_crc_ok"}, int'(crc_ok), 0);
    chk({tag, "_error_seen"}, int'(error_seen), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // Sends one frame; err_at = index of byte preceded by an in_error pulse (-1 none);
  // partial != 0 requires eoc_last.
  task automatic send_frame(input logic [7:0] b[$], input int partial, input int err_at,
                            input bit eoc_last);
    status_t     s;
    byte_t       e;
    int          n, stored, lb;
    bit          err, ovf, last;
    logic [15:0] c;
    logic [2:0]  bits;
    n = b.size();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    idle();
    bq.delete();
    chk("soc_busy", int'(busy), 1);
    chk("soc_out_valid", int'(out_valid), 0);
    chk("soc_len_clear", int'(frame_len), 0);
    chk("soc_err_clear", int'(error_seen), 0);
    // reference model at frame level
    stored = 0; lb = 0; err = 0; ovf = 0; c = 16'h6363;
    for (int i = 0; i < n; i++) begin
      if (i == err_at) begin
        err = 1;
        break;
      end
      if (stored < MAX) begin
        e.d = b[i];
        e.l = 1'b0;
        bq.push_back(e);
        stored++;
        lb = (i == n - 1) ? partial : 0;
        if (lb == 0) c = crc_byte(c, b[i]);
      end else begin
        ovf = 1;
      end
    end
    if (stored > 0) begin
      e = bq.pop_back();
      e.l = 1'b1;
      bq.push_back(e);
    end
    s.len = stored;
    s.lb  = lb;
    s.ok  = int'((c == 16'h0000) && (stored >= 3) && (lb == 0) && !err && !ovf);
    s.err = int'(err);
    s.ovf = int'(ovf);
    s.cyc = 0;
    // stimulus
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      if (i == err_at) drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 3'd0);
      last = (i == n - 1);
      bits = last ? 3'(partial) : 3'd0;
      drive(1'b0, last && eoc_last, 1'b0, 1'b1, b[i], bits);
      if (last && eoc_last) s.cyc = cyc;
    end
    if (!(n > 0 && eoc_last)) begin
      repeat ($urandom_range(0, 2)) idle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
      s.cyc = cyc;
    end
    sq.push_back(s);
    idle();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sq.size() != 0 || bq.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      fail_now("drain_timeout");
      sq.delete();
      bq.delete();
    end
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("idle_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    logic [7:0]  fr[$];
    logic [15:0] c;
    int          n, partial, err_at;
    bit          eoc_last;

    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("after_rst");

    // HLTA with valid CRC_A
    rdy_mode = 2;
    fr = '{8'h50, 8'h00, 8'h57, 8'hCD};
    send_frame(fr, 0, -1, 0);
    wait_drain();
    chk("hlta_len", int'(frame_len), 4);
    chk("hlta_crc_ok", int'(crc_ok), 1);

    // REQA short frame, 7 bits coincident with eoc
    fr = '{8'h26};
    send_frame(fr, 7, -1, 1);
    wait_drain();
    chk("reqa_len", int'(frame_len), 1);
    chk("reqa_last_bits", int'(last_bits), 7);
    chk("reqa_crc_ok", int'(crc_ok), 0);

    // corrupted CRC
    rdy_mode = 0;
    fr = '{8'h50, 8'h00, 8'h57, 8'hCC};
    send_frame(fr, 0, -1, 1);
    wait_drain();
    chk("badcrc_crc_ok", int'(crc_ok), 0);
    chk("badcrc_len", int'(frame_len), 4);

    // overflow: 20 bytes into a 16-byte buffer
    fr.delete();
    for (int i = 0; i < 20; i++) fr.push_back(8'(i * 7 + 1));
    send_frame(fr, 0, -1, 0);
    wait_drain();
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_len", int'(frame_len), 16);
    chk("ovf_crc_ok", int'(crc_ok), 0);

    // rx error after two bytes, two more bytes ignored
    fr = '{8'h93, 8'h20, 8'h11, 8'h22};
    send_frame(fr, 0, 2, 0);
    wait_drain();
    chk("err_flag", int'(error_seen), 1);
    chk("err_len", int'(frame_len), 2);
    chk("err_crc_ok", int'(crc_ok), 0);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(0, 19);
      fr.delete();
      if (n >= 3 && $urandom_range(0, 1) == 1) begin
        c = 16'h6363;
        for (int i = 0; i < n - 2; i++) begin
          fr.push_back(8'($urandom));
          c = crc_byte(c, fr[i]);
        end
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
      end else begin
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
      end
      partial  = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      err_at   = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      eoc_last = (partial != 0) ? 1'b1 : ((n > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      send_frame(fr, partial, err_at, eoc_last);
      wait_drain();
    end

    // backpressure, then abort mid-drain with a new frame
    rdy_mode = 1;
    fr = '{8'h50, 8'h00, 8'h57, 8'hCD};
    send_frame(fr, 0, -1, 0);
    repeat (8) @(posedge clk);
    #1 rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1 rdy_mode = 1;
    chk("bp_remaining", bq.size(), 2);
    fr = '{8'h93, 8'h70, 8'h01, 8'h02, 8'h03};
    send_frame(fr, 0, -1, 1);
    rdy_mode = 0;
    wait_drain();
    chk("abort_new_len", int'(frame_len), 5);

    // async reset in the middle of capture
    rdy_mode = 2;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 3'd0);
    idle();
    chk("pre_rst_len", int'(frame_len), 2);
    chk("pre_rst_busy", int'(busy), 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(negedge clk) rst = 1'b0;
    fr = '{8'h50, 8'h00, 8'h57, 8'hCD};
    send_frame(fr, 0, -1, 1);
    wait_drain();
    chk("post_rst_crc_ok", int'(crc_ok), 1);

    repeat (4) @(posedge clk);
    chk("sq_empty", sq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
Frame-level sequencer behind the rx bit-to-byte deserialiser. Captures one PICC-bound frame into a local byte buffer and tracks byte count, partial last byte, errors and overflow. Checks CRC_A over the whole frame, then issues a one-cycle frame_done with status. Afterwards it drains the buffered bytes to the protocol layer over a valid/ready handshake.

Parameters:
MAX_BYTES, 16, buffer depth in bytes (frames longer than this flag overflow)
LEN_W, $clog2(MAX_BYTES+1), width of frame_len

Ports:
clk  input  1  13.56MHz clock
rst  input  1  asynchronous active-high reset
in_soc  input  1  start of comms pulse from deserialiser
in_eoc  input  1  end of comms pulse
in_error  input  1  rx error pulse
in_data_valid  input  1  byte (or partial byte when coincident with in_eoc) valid
in_data  input  8  received byte, LSb first received
in_data_bits  input  3  bits in in_data; 0 = full byte, 1..7 = partial
frame_done  output  1  one-cycle pulse: frame captured and status valid
frame_len  output  LEN_W  bytes stored, including a partial last byte
last_bits  output  3  bits in last byte (0 = full byte)
crc_ok  output  1  CRC_A residue check passed
error_seen  output  1  in_error occurred during the frame
overflow  output  1  more than MAX_BYTES bytes arrived
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  8  buffered byte
out_last  output  1  out_data is final byte of the frame
busy  output  1  state != IDLE

Behaviour:
- Reset (rst high, async): state=IDLE. All outputs 0. Write pointer, read pointer, frame_len and CRC are cleared. CRC register loads 0x6363.
- States: IDLE, RX, RX_ERR, CHECK, DRAIN.
- IDLE: in_soc -> RX. Clears len, last_bits, error_seen, overflow, crc_ok, pointers; CRC=0x6363.
- RX, on in_data_valid with data_bits==0 and count<MAX_BYTES: write buf[wr_ptr], wr_ptr++. CRC_A is updated: reflected poly 0x8408, LSb first, 8 bit-steps per byte (may be unrolled combinationally).
- RX, in_data_valid when count==MAX_BYTES: byte discarded, overflow<=1, CRC frozen.
- RX, in_data_valid with data_bits!=0: legal only together with in_eoc. The partial byte is stored, last_bits<=data_bits, and it is excluded from the CRC. A partial byte without in_eoc sets error_seen and goes to RX_ERR.
- RX, in_error: error_seen<=1 -> RX_ERR. A coincident in_data_valid is ignored.
- RX_ERR: ignore data until in_eoc -> CHECK.
- RX, in_eoc: -> CHECK. A coincident in_data_valid is processed first.
- RX or RX_ERR, in_soc: restart as from IDLE. No frame_done for the aborted frame.
- CHECK (1 cycle): crc_ok<=1 iff CRC==0x0000 && len>=3 && last_bits==0 && !error_seen && !overflow. frame_done pulses.
- CHECK exit: -> DRAIN if len!=0, else -> IDLE.
- Latency: frame_done is high exactly 2 cycles after the in_eoc cycle, i.e. in the cycle the state leaves CHECK (registered).
- frame_len, last_bits, crc_ok, error_seen, overflow hold until the next in_soc.
- DRAIN: out_valid=1 and out_data=buf[rd_ptr]; out_last=(rd_ptr==len-1).
- DRAIN transfer: occurs when out_valid&&out_ready, then rd_ptr++. The transfer with out_last -> IDLE with out_valid=0 next cycle. out_valid stays high and out_data stable while out_ready is low.
- DRAIN, in_soc: flush remaining bytes (out_valid<=0), restart capture as from IDLE.
- Errored and overflowed frames are still drained; the consumer uses the status to discard them.
- Simultaneous in_soc and in_eoc: in_soc takes priority (start new frame).
- in_eoc in IDLE or DRAIN: ignored.
- busy = (state!=IDLE).

Test Plan:
- HLTA: soc, bytes 0x50 0x00 0x57 0xCD, eoc -> frame_done 2 cycles after eoc. Status: len=4, last_bits=0, crc_ok=1, error_seen=0. Drain yields 50,00,57,CD with out_last on CD.
- REQA short frame: soc, eoc coincident with data_valid, data=0x26, data_bits=7 -> len=1, last_bits=7, crc_ok=0. One byte 0x26 drained with out_last.
- Corrupted CRC: 0x50 0x00 0x57 0xCC -> crc_ok=0, len=4, all 4 bytes drained.
- Overflow: 20 full bytes with MAX_BYTES=16 -> overflow=1, len=16, crc_ok=0. Bytes 0..15 drained, bytes 16..19 never appear.
- Error: in_error after byte 2, then 2 more bytes, then eoc -> error_seen=1, len=2, crc_ok=0, 2 bytes drained.
- Backpressure and abort: hold out_ready low 5 cycles -> out_data stable. Then in_soc mid-drain -> out_valid drops next cycle and a new frame captures normally. Async rst mid-RX -> all outputs 0 immediately, state IDLE.
